cacheline_arbiter: RTL and testbench
====================================

// Module: cacheline_arbiter
// PURPOSE
//  Shares one physical-memory line port between the I-cache (read-only) and D-cache (read/write) miss paths.
//  Sits between both caches and pmem, below the cpu's inst_*/data_* ports.
//  Serves one line transaction at a time, with round-robin fairness when both sides request together.
//  Latches address/data at grant, so the mem side stays stable for the whole transaction.
// PARAMETERS
//  ADDR_W  32   line address width (low log2(LINE_W/8) bits passed through unmodified)
//  LINE_W  256  cacheline width in bits
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  i_read     in   1       I-cache line read request, held until i_resp
//  i_addr     in   ADDR_W  I-cache line address
//  i_rdata    out  LINE_W  line returned to I-cache, valid when i_resp
//  i_resp     out  1       I-side transaction complete (1 cycle)
//  d_read     in   1       D-cache line read request, held until d_resp
//  d_write    in   1       D-cache line writeback request, held until d_resp
//  d_addr     in   ADDR_W  D-cache line address
//  d_wdata    in   LINE_W  writeback line
//  d_rdata    out  LINE_W  line returned to D-cache, valid when d_resp
//  d_resp     out  1       D-side transaction complete (1 cycle)
//  mem_read   out  1       pmem line read, held until mem_resp
//  mem_write  out  1       pmem line write, held until mem_resp
//  mem_addr   out  ADDR_W  latched address of the granted request
//  mem_wdata  out  LINE_W  latched writeback data
//  mem_rdata  in   LINE_W  pmem read data, valid with mem_resp
//  mem_resp   in   1       pmem transaction complete (1 cycle)
// BEHAVIOUR
//  - States: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR. Reset -> IDLE, last_grant=GRANT_I.
//  - Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_resp=0, d_resp=0.
//  - Reset values (rdata ports): i_rdata/d_rdata are don't-care while their resp=0.
//  - IDLE, only I pending: -> SERVE_I. Latch i_addr.
//  - IDLE, only D pending: -> SERVE_D_RD or SERVE_D_WR. Latch d_addr and d_wdata.
//  - IDLE, both pending: grant the side != last_grant, then update last_grant.
//  - First tie after reset therefore goes to D.
//  - mem_read/mem_write are registered.
//    - Request seen in IDLE at cycle t -> mem_read or mem_write high from t+1.
//    - Held constant until mem_resp.
//  - Addr/wdata latched at grant; requester input changes mid-transaction are ignored.
//  - mem_resp at cycle k while SERVE_x:
//    - Granted side's resp=1 in cycle k (combinational).
//    - rdata = mem_rdata in cycle k.
//    - mem_read/mem_write deassert at k+1; state -> IDLE at k+1.
//  - Requesters drop their request in the cycle after their resp.
//  - Next grant is evaluated in IDLE at k+1, so back-to-back mem transactions have exactly 1 idle cycle.
//  - mem_resp while in IDLE is ignored; no resp is produced.
//  - The non-granted resp stays 0 at all times.
//  - d_read and d_write together is illegal. Bench assertion flags it; RTL treats it as write.
//  - rst asserted mid-transaction:
//    - Next cycle: IDLE, all outputs at reset values, in-flight transaction abandoned, no resp issued.
//    - pmem model must also be reset.
//  - Worst-case wait for either side: one full transaction of the other side (round-robin, no starvation).
// STRUCTURE
//  - Package arbiter_types (new, beside rv32i_types):
//    - arb_state_t enum {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR}.
//    - grant_t enum {GRANT_I, GRANT_D}.
//  - Sub-module rr_arbiter2: 2-requester round-robin.
//    - Inputs: req[1:0], last_grant. Output: grant.
//    - Purely combinational; last_grant register lives in the parent.
//  - Parent holds: state FSM, latch registers, resp/rdata steering mux.
// TESTING
//  1. i_read=1, i_addr=0x60 alone; mem_resp 5 cycles after mem_read.
//     -> mem_read=1 from t+1, mem_addr=0x60; i_resp=1 for 1 cycle with i_rdata=mem_rdata; d_resp stays 0.
//  2. d_write=1, d_addr=0x80, d_wdata=0xA5..A5.
//     -> mem_write=1, mem_addr=0x80, mem_wdata=0xA5..A5 held until mem_resp; d_resp pulses once.
//  3. After reset, i_read and d_read rise in the same cycle.
//     -> D served first, then I. mem_read low for exactly 1 cycle between them. Then D again on next tie.
//  4. Change i_addr from 0x60 to 0x100 while SERVE_I waits for pmem.
//     -> mem_addr stays 0x60 for the whole transaction.
//  5. Assert rst 2 cycles into SERVE_D_RD.
//     -> Next cycle: mem_read=0, IDLE, no d_resp; a new i_read is then served normally.
//  6. Spurious mem_resp pulse in IDLE.
//     -> No i_resp/d_resp; state stays IDLE.

Source files
------------

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter: FSM states and grant identifiers.
// Pure type definitions, no latency or flow-control implications.
package arbiter_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D_RD,
        SERVE_D_WR
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Cache-side and pmem-side line signals of the arbiter, bundled as one interface.
// slave = arbiter view; master = the caches and pmem that surround it.
interface cacheline_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cacheline_arbiter_rr.sv
// Two-requester round-robin pick (bit 0 = I, bit 1 = D); combinational, zero latency.
// On a tie the side that did not win last time is chosen; the history register lives in the parent.
module rr_arbiter2
    import arbiter_types::*;
(
    input  logic   [1:0] req,
    input  grant_t       last_grant,
    output grant_t       grant
);

    always_comb begin
        grant = GRANT_I;
        if (req[1] && req[0]) begin
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (req[1]) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one pmem line port between I-cache and D-cache; mem_read/mem_write rise one cycle after grant.
// One transaction in flight; the loser keeps its request held until it is served next.
module cacheline_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input logic                clk,
    input logic                rst,
    cacheline_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    grant_t            grant;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              i_pend, d_pend;

    assign i_pend = bus.i_read;
    assign d_pend = bus.d_read | bus.d_write;

    rr_arbiter2 u_rr (
        .req        ({d_pend, i_pend}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // A write wins over a simultaneous read on the D side (illegal combination).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    last_grant_d = grant;
                    if (grant == GRANT_I) begin
                        state_d = SERVE_I;
                        addr_d  = bus.i_addr;
                    end else begin
                        state_d = bus.d_write ? SERVE_D_WR : SERVE_D_RD;
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end
                end
            end
            default: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                end
            end
        endcase
        mem_read_d  = (state_d == SERVE_I) || (state_d == SERVE_D_RD);
        mem_write_d = (state_d == SERVE_D_WR);
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Responses are gated by rst so an abandoned transaction never completes.
    assign bus.i_resp  = !rst && bus.mem_resp && (state_q == SERVE_I);
    assign bus.d_resp  = !rst && bus.mem_resp &&
                         ((state_q == SERVE_D_RD) || (state_q == SERVE_D_WR));
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: vector table of request patterns plus reset and spurious-resp sequences.
// Expected pmem transactions and responses are queued when requests are driven and retired on resp.
module tb_cacheline_arbiter;
    import arbiter_types::*;

    localparam int AW = 32;
    localparam int LW = 256;

    typedef logic [AW-1:0] addr_t;
    typedef logic [LW-1:0] line_t;

    typedef struct {
        bit    do_rst;
        bit    ir;
        bit    dr;
        bit    dw;
        addr_t ia;
        addr_t da;
        line_t wd;
        int    lat;
        bit    exp_d_first;
    } vec_t;

    typedef struct {
        bit    side_d;
        bit    wr;
        addr_t addr;
        line_t wdata;
        line_t rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;

    cacheline_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    txn_t sb[$];
    vec_t vecs[8];

    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            assert (!(bus.d_read === 1'b1 && bus.d_write === 1'b1))
                else $error("FAIL illegal_d_rw: d_read and d_write both high");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_addr(input string name, input addr_t act, input addr_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic vec_t mk(bit r, bit ir, bit dr, bit dw, addr_t ia, addr_t da,
                                line_t wd, int lat, bit dfirst);
        vec_t v;
        v.do_rst = r;   v.ir = ir;   v.dr = dr;   v.dw = dw;
        v.ia = ia;      v.da = da;   v.wd = wd;   v.lat = lat;
        v.exp_d_first = dfirst;
        return v;
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        bus.i_read    = 1'b0;
        bus.i_addr    = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one request pattern, plays pmem, and checks every cycle until all queued txns retire.
    task automatic run_vec(input vec_t v);
        txn_t ti, td, cur;
        int   cyc = 0, cnt = 0, wait_cyc = 0, ntx = 0;
        bit   busy = 0, drop_i = 0, drop_d = 0;

        if (v.do_rst) do_reset();

        bus.i_read  = v.ir;
        bus.i_addr  = v.ia;
        bus.d_read  = v.dr;
        bus.d_write = v.dw;
        bus.d_addr  = v.da;
        bus.d_wdata = v.wd;

        ti.side_d = 1'b0; ti.wr = 1'b0;  ti.addr = v.ia; ti.wdata = '0;   ti.rdata = rand_line();
        td.side_d = 1'b1; td.wr = v.dw;  td.addr = v.da; td.wdata = v.wd; td.rdata = rand_line();
        if (v.ir && (v.dr || v.dw)) begin
            if (v.exp_d_first) begin sb.push_back(td); sb.push_back(ti); end
            else               begin sb.push_back(ti); sb.push_back(td); end
        end else if (v.ir) begin
            sb.push_back(ti);
        end else begin
            sb.push_back(td);
        end

        while (sb.size() > 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (drop_i) begin bus.i_read = 1'b0; drop_i = 0; end
            if (drop_d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; drop_d = 0; end
            bus.mem_resp = 1'b0;
            #1;
            if (bus.mem_read || bus.mem_write) begin
                if (!busy) begin
                    busy = 1;
                    cnt  = 0;
                    cur  = sb[0];
                    chk_int("start_gap", wait_cyc, (ntx == 0) ? 0 : 1);
                    chk_bit("mem_read_type", bus.mem_read, !cur.wr);
                    chk_bit("mem_write_type", bus.mem_write, cur.wr);
                    chk_addr("mem_addr", bus.mem_addr, cur.addr);
                    if (cur.wr) chk_line("mem_wdata", bus.mem_wdata, cur.wdata);
                end else begin
                    chk_addr("mem_addr_hold", bus.mem_addr, cur.addr);
                    chk_bit("mem_write_hold", bus.mem_write, cur.wr);
                    if (cur.wr) chk_line("mem_wdata_hold", bus.mem_wdata, cur.wdata);
                end
                cnt++;
                if (cnt == 2) begin
                    if (cur.side_d) begin
                        bus.d_addr  = bus.d_addr ^ 32'h160;
                        bus.d_wdata = ~bus.d_wdata;
                    end else begin
                        bus.i_addr = bus.i_addr ^ 32'h160;
                    end
                end
                if (cnt >= v.lat) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = cur.rdata;
                    #1;
                    chk_bit("i_resp", bus.i_resp, !cur.side_d);
                    chk_bit("d_resp", bus.d_resp, cur.side_d);
                    if (cur.side_d) chk_line("d_rdata", bus.d_rdata, cur.rdata);
                    else            chk_line("i_rdata", bus.i_rdata, cur.rdata);
                    cur = sb.pop_front();
                    if (cur.side_d) drop_d = 1; else drop_i = 1;
                    busy     = 0;
                    ntx++;
                    wait_cyc = 0;
                end else begin
                    chk_bit("no_early_resp", bus.i_resp | bus.d_resp, 1'b0);
                end
            end else begin
                if (busy) chk_bit("mem_held", bus.mem_read | bus.mem_write, 1'b1);
                wait_cyc++;
                chk_bit("idle_no_resp", bus.i_resp | bus.d_resp, 1'b0);
            end
        end

        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: %0d transactions outstanding, expected 0", sb.size());
            sb.delete();
        end

        @(posedge clk);
        #1;
        if (drop_i) bus.i_read = 1'b0;
        if (drop_d) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
        bus.mem_resp = 1'b0;
        #1;
        chk_bit("mem_released", bus.mem_read | bus.mem_write, 1'b0);
        chk_bit("resp_single", bus.i_resp | bus.d_resp, 1'b0);
    endtask

    initial begin
        vecs[0] = mk(1, 1, 0, 0, 32'h60,  32'h0,   '0,               5, 0);
        vecs[1] = mk(0, 0, 0, 1, 32'h0,   32'h80,  {32{8'hA5}},      3, 1);
        vecs[2] = mk(1, 1, 1, 0, 32'h200, 32'h300, '0,               4, 1);
        vecs[3] = mk(0, 1, 0, 1, 32'h220, 32'h320, {8{32'hDEADBEEF}}, 3, 1);
        vecs[4] = mk(0, 1, 0, 0, 32'h240, 32'h0,   '0,               2, 0);
        vecs[5] = mk(0, 1, 1, 0, 32'h260, 32'h360, '0,               3, 1);
        vecs[6] = mk(0, 0, 1, 0, 32'h0,   32'h380, '0,               1, 1);
        vecs[7] = mk(0, 1, 0, 1, 32'h280, 32'h3A0, {8{32'h0F1E2D3C}}, 2, 0);

        do_reset();
        chk_bit("rst_mem_read", bus.mem_read, 1'b0);
        chk_bit("rst_mem_write", bus.mem_write, 1'b0);
        chk_addr("rst_mem_addr", bus.mem_addr, '0);
        chk_line("rst_mem_wdata", bus.mem_wdata, '0);
        chk_bit("rst_i_resp", bus.i_resp, 1'b0);
        chk_bit("rst_d_resp", bus.d_resp, 1'b0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset two cycles into a D read: transaction dropped, no resp.
        do_reset();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h400;
        @(posedge clk);
        #2;
        chk_bit("t5_started", bus.mem_read, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_bit("t5_rst_no_dresp", bus.d_resp, 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.d_read = 1'b0;
        #1;
        chk_bit("t5_mem_read_cleared", bus.mem_read, 1'b0);
        chk_addr("t5_mem_addr_cleared", bus.mem_addr, '0);
        chk_bit("t5_no_dresp", bus.d_resp, 1'b0);
        @(posedge clk);
        #2;
        chk_bit("t5_stays_idle", bus.mem_read | bus.mem_write, 1'b0);
        run_vec(mk(0, 1, 0, 0, 32'h500, 32'h0, '0, 3, 0));

        // Spurious pmem response while idle.
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rand_line();
        #1;
        chk_bit("t6_no_iresp", bus.i_resp, 1'b0);
        chk_bit("t6_no_dresp", bus.d_resp, 1'b0);
        @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        #1;
        chk_bit("t6_idle_mem", bus.mem_read | bus.mem_write, 1'b0);
        run_vec(mk(0, 0, 0, 1, 32'h0, 32'h600, {16{16'h1234}}, 2, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
